mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, number of 32-bit words in the storage array (power of two).
REQ-003 SHALL have port Clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port Rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  request from the memory-stage initiator is present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_op  input  3  access size code: 0 word, 1 byte unsigned, 2 byte signed, 3 half unsigned, 4 half signed.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response is present.
REQ-012 SHALL have port rsp_ready  input  1  initiator consumes the response this cycle.
REQ-013 SHALL have port rsp_rdata  output  32  load result, already extended.
REQ-014 SHALL have port rsp_err  output  1  the request was faulted; no memory effect.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-016 SHALL accept a request on the edge where req_valid & req_ready; capture we/op/addr/wdata on that edge.
REQ-017 SHALL assert rsp_valid exactly LATENCY cycles after the accepting edge.
- LATENCY=1: IDLE->RESP directly.
- Otherwise: IDLE->WAIT; a down-counter loaded with LATENCY-1 moves WAIT->RESP when it reaches 1.
REQ-018 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1; on that edge go RESP->IDLE and drop rsp_valid.
REQ-019 SHALL ignore req_valid outside IDLE; no queuing; max throughput one request per LATENCY+1 cycles.
REQ-020 SHALL index the word as addr[log2(DEPTH_WORDS)+1:2]; higher address bits ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-021 SHALL use little-endian lanes: byte lane = addr[1:0]; half lane = addr[1] (0 low half, 1 high half).
REQ-022 SHALL flag a fault (rsp_err=1, rsp_rdata=0, no write) when:
- word access has addr[1:0]!=0;
- half access has addr[0]!=0;
- req_op is 5..7.
REQ-023 SHALL commit a store only on the edge entering RESP, writing only the addressed lanes (byte: wdata[7:0]; half: wdata[15:0]); other lanes are unchanged.
REQ-024 SHALL return rsp_rdata=0, rsp_err=0 for a successful store.
REQ-025 SHALL read loads from the array state at the edge entering RESP, with extension:
- byte signed: sign-extend bit 7; byte unsigned: zero-extend;
- half signed/unsigned: likewise on bit 15;
- word: unmodified.
REQ-026 SHALL, for a load following a store to the same word, return the post-store data.

Reset
REQ-027 SHALL, while Rst=0, force state IDLE, counter 0, rsp_valid=0, rsp_rdata=0, rsp_err=0, and clear every storage word to 0, independent of Clk.
REQ-028 SHALL, when Rst is asserted mid-operation (WAIT or RESP), abort the request; an uncommitted store has no effect and no response is produced.
REQ-029 SHALL present req_ready=1 in the first cycle after Rst deasserts.

Verification
REQ-030 Verification: LATENCY=2; store word 0x12345678 @0x10; rsp_ready=1 -> rsp_valid 2 cycles after accept, err=0; then load word @0x10 -> rdata 0x12345678.
REQ-031 Verification: store byte 0xAB @0x13 over that word; then load byte signed @0x13 -> 0xFFFFFFAB; load byte unsigned -> 0x000000AB; load word @0x10 -> 0xAB345678.
REQ-032 Verification: store half 0x8001 @0x22; then load half signed @0x22 -> 0xFFFF8001; load half @0x21 -> rsp_err=1, rdata 0; word @0x20 unchanged (0x80010000).
REQ-033 Verification: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rdata stable, req_ready=0, and a second req_valid is not accepted until the cycle after rsp_ready=1.
REQ-034 Verification: DEPTH_WORDS=1024; store word 0xCAFEF00D @0x1004; then load @0x4 -> 0xCAFEF00D (wrap).
REQ-035 Verification: accept a store word 0xDEADBEEF @0x30, pulse Rst low while in WAIT -> rsp_valid never asserts; after reset, load @0x30 -> 0x00000000.

Source files
------------

// File: rtl/mem_responder.sv
// Single-outstanding memory responder for a memory-stage initiator: fixed-latency
// load/store with byte/half/word lanes, alignment faults and a clearable storage array.
`timescale 1ns/1ps
module mem_responder #(
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0]  LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t       state, state_nx;
  logic [3:0]   cnt;
  logic         cap_we;
  logic [2:0]   cap_op;
  logic [AW+1:0] cap_addr;
  logic [31:0]  cap_wdata;
  logic [31:0]  mem [DEPTH_WORDS];

  logic          accept, enter_resp;
  logic          cur_we;
  logic [2:0]    cur_op;
  logic [AW+1:0] cur_addr;
  logic [31:0]   cur_wdata;
  logic [AW-1:0] widx;
  logic [1:0]    lane;
  logic          fault;
  logic [31:0]   old_word, wr_word, ld_data;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;

  assign req_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_nx   = state;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state)
      IDLE: if (req_valid) begin
        accept = 1'b1;
        if (LATENCY == 1) begin
          state_nx   = RESP;
          enter_resp = 1'b1;
        end else begin
          state_nx = WAIT;
        end
      end
      WAIT: if (cnt == 4'd1) begin
        state_nx   = RESP;
        enter_resp = 1'b1;
      end
      RESP: if (rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With LATENCY=1 the access happens on the accepting edge, so the request
  // fields come straight from the ports rather than the capture registers.
  always_comb begin
    cur_we    = (state == IDLE) ? req_we            : cap_we;
    cur_op    = (state == IDLE) ? req_op            : cap_op;
    cur_addr  = (state == IDLE) ? req_addr[AW+1:0]  : cap_addr;
    cur_wdata = (state == IDLE) ? req_wdata         : cap_wdata;
    widx      = cur_addr[AW+1:2];
    lane      = cur_addr[1:0];
    old_word  = mem[widx];
    ld_byte   = old_word[{lane, 3'b000} +: 8];
    ld_half   = old_word[{lane[1], 4'b0000} +: 16];
    wr_word   = old_word;
    ld_data   = '0;
    fault     = 1'b0;
    case (cur_op)
      3'd0: begin
        fault   = (lane != 2'd0);
        wr_word = cur_wdata;
        ld_data = old_word;
      end
      3'd1, 3'd2: begin
        wr_word[{lane, 3'b000} +: 8] = cur_wdata[7:0];
        ld_data = {{24{(cur_op == 3'd2) & ld_byte[7]}}, ld_byte};
      end
      3'd3, 3'd4: begin
        fault = lane[0];
        wr_word[{lane[1], 4'b0000} +: 16] = cur_wdata[15:0];
        ld_data = {{16{(cur_op == 3'd4) & ld_half[15]}}, ld_half};
      end
      default: fault = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cap_we    <= 1'b0;
      cap_op    <= '0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        cap_we    <= req_we;
        cap_op    <= req_op;
        cap_addr  <= req_addr[AW+1:0];
        cap_wdata <= req_wdata;
        cnt       <= LAT_M1;
      end else if (state == WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (enter_resp) begin
        rsp_err   <= fault;
        rsp_rdata <= (fault || cur_we) ? '0 : ld_data;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      for (int unsigned i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (enter_resp && cur_we && !fault) begin
      mem[widx] <= wr_word;
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Randomized + directed bench for mem_responder, checked every cycle against a
// transaction-level model built on a plain word array.
`timescale 1ns/1ps
module tb_mem_responder;

  localparam int unsigned LAT   = 2;
  localparam int unsigned DEPTH = 1024;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  mem_responder #(.LATENCY(LAT), .DEPTH_WORDS(DEPTH)) dut (
    .Clk(Clk), .Rst(Rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  logic [31:0] mdl_mem [DEPTH];
  bit          m_busy, m_resp;
  longint      cyc = 0, m_start = 0;
  logic        m_we;
  logic [2:0]  m_op;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_err;

  function automatic void model_exec();
    int unsigned idx = (m_addr >> 2) % DEPTH;
    int unsigned off = m_addr % 4;
    int unsigned sz  = (m_op == 0) ? 4 : (m_op <= 2) ? 1 : 2;
    logic [63:0] mask, val;
    m_err   = (m_op > 4) || ((off % sz) != 0);
    m_rdata = '0;
    if (m_err) return;
    mask = ((64'd1 << (8 * sz)) - 64'd1) << (8 * off);
    if (m_we) begin
      val = (64'(mdl_mem[idx]) & ~mask) | ((64'(m_wdata) << (8 * off)) & mask);
      mdl_mem[idx] = val[31:0];
    end else begin
      val = (64'(mdl_mem[idx]) >> (8 * off)) & ((64'd1 << (8 * sz)) - 64'd1);
      if ((m_op == 2 || m_op == 4) && val[8 * sz - 1]) val = val | (~64'd0 << (8 * sz));
      m_rdata = val[31:0];
    end
  endfunction

  always @(posedge Clk) begin
    cyc++;
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
      m_busy = 0;
      m_resp = 0;
    end else begin
      if (m_resp && rsp_ready) begin
        m_resp = 0;
        m_busy = 0;
      end else if (!m_busy && req_valid) begin
        m_busy  = 1;
        m_start = cyc + LAT - 1;
        m_we    = req_we;
        m_op    = req_op;
        m_addr  = req_addr;
        m_wdata = req_wdata;
      end
      if (m_busy && !m_resp && cyc == m_start) begin
        model_exec();
        m_resp = 1;
      end
    end
    #1;
    chk("req_ready", 32'(req_ready), 32'(!m_busy));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_resp));
    if (m_resp) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", 32'(rsp_err), 32'(m_err));
    end
    if (!Rst) begin
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", 32'(rsp_err), 32'h0);
    end
  end

  // ---------------- driver ----------------
  task automatic send(input logic we, input logic [2:0] op, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got req_ready=0 expected 1");
    end
    req_we = we; req_op = op; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    @(negedge Clk);
    req_valid = 1'b0;
    req_we = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
  endtask

  // Called at the negedge right after the accepting edge (lat starts at 1).
  task automatic recv(input int dly, output logic [31:0] rd, output logic er, output int lat);
    lat = 1;
    while (!rsp_valid && lat < 40) begin
      @(negedge Clk);
      lat++;
    end
    rd = '0;
    er = 1'b0;
    if (!rsp_valid) begin
      checks++;
      errors++;
      $display("FAIL recv_timeout: got rsp_valid=0 expected 1");
      return;
    end
    rd = rsp_rdata;
    er = rsp_err;
    repeat (dly) @(negedge Clk);
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
  endtask

  task automatic xact(input string name, input logic we, input logic [2:0] op,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_rd, input logic exp_er);
    logic [31:0] rd;
    logic er;
    int lat;
    send(we, op, addr, wdata);
    recv(0, rd, er, lat);
    chk({name, "_rdata"}, rd, exp_rd);
    chk({name, "_err"}, 32'(er), 32'(exp_er));
    chk({name, "_lat"}, lat, LAT);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, a;
    logic er;
    int lat;
    logic [2:0] op;

    #1 Rst = 1'b0;
    repeat (3) @(negedge Clk);
    chk("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    chk("reset_err", 32'(rsp_err), 32'h0);
    Rst = 1'b1;
    @(negedge Clk);
    chk("ready_after_reset", 32'(req_ready), 32'h1);

    xact("st_word",   1, 3'd0, 32'h10, 32'h12345678, 32'h0, 0);
    xact("ld_word",   0, 3'd0, 32'h10, 32'h0, 32'h12345678, 0);
    xact("st_byte",   1, 3'd1, 32'h13, 32'h5A5A5AAB, 32'h0, 0);
    xact("ld_byte_s", 0, 3'd2, 32'h13, 32'h0, 32'hFFFFFFAB, 0);
    xact("ld_byte_u", 0, 3'd1, 32'h13, 32'h0, 32'h000000AB, 0);
    xact("ld_word2",  0, 3'd0, 32'h10, 32'h0, 32'hAB345678, 0);
    xact("st_misal",  1, 3'd0, 32'h11, 32'hFFFFFFFF, 32'h0, 1);
    xact("ld_bad_op", 0, 3'd5, 32'h10, 32'h0, 32'h0, 1);
    xact("ld_word3",  0, 3'd0, 32'h10, 32'h0, 32'hAB345678, 0);
    xact("st_half",   1, 3'd3, 32'h22, 32'h77778001, 32'h0, 0);
    xact("ld_half_s", 0, 3'd4, 32'h22, 32'h0, 32'hFFFF8001, 0);
    xact("ld_half_m", 0, 3'd3, 32'h21, 32'h0, 32'h0, 1);
    xact("ld_word20", 0, 3'd0, 32'h20, 32'h0, 32'h80010000, 0);

    // Back-pressure: a second request is held on req_valid the whole time.
    send(0, 3'd0, 32'h10, 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_op = 3'd1; req_addr = 32'h13; req_wdata = '0;
    @(negedge Clk);
    repeat (5) begin
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, 32'hAB345678);
      chk("hold_ready", 32'(req_ready), 32'h0);
      @(negedge Clk);
    end
    rsp_ready = 1'b1;
    @(negedge Clk);
    rsp_ready = 1'b0;
    chk("release_ready", 32'(req_ready), 32'h1);
    chk("release_valid", 32'(rsp_valid), 32'h0);
    @(negedge Clk);
    chk("second_accepted", 32'(req_ready), 32'h0);
    req_valid = 1'b0;
    recv(0, rd, er, lat);
    chk("second_rdata", rd, 32'h000000AB);
    chk("second_lat", lat, LAT);

    xact("st_wrap", 1, 3'd0, 32'h1004, 32'hCAFEF00D, 32'h0, 0);
    xact("ld_wrap", 0, 3'd0, 32'h4, 32'h0, 32'hCAFEF00D, 0);

    // Reset while the store is still in WAIT.
    send(1, 3'd0, 32'h30, 32'hDEADBEEF);
    Rst = 1'b0;
    repeat (3) begin
      @(negedge Clk);
      chk("abort_valid", 32'(rsp_valid), 32'h0);
    end
    Rst = 1'b1;
    repeat (3) begin
      @(negedge Clk);
      chk("abort_valid_post", 32'(rsp_valid), 32'h0);
    end
    xact("ld_aborted", 0, 3'd0, 32'h30, 32'h0, 32'h0, 0);
    xact("ld_cleared", 0, 3'd0, 32'h10, 32'h0, 32'h0, 0);

    repeat (300) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a  = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 15)) << 12);
      send(1'($urandom_range(0, 1)), op, a, $urandom);
      recv($urandom_range(0, 3), rd, er, lat);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge Clk);
    end

    @(negedge Clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
